// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR controller. It holds the sample delay line and the
// coefficient bank, and steps one shared external combinational multiplier
// through every tap. The products are accumulated and the result is
// presented over a valid/ready handshake.
module fir_mac_sequencer #(
   parameter int NTAPS = 3,
   parameter int W     = 32,
   parameter int AW    = $clog2(NTAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [W-1:0]  coef_wdata,
   input  logic          x_valid,
   output logic          x_ready,
   input  logic [W-1:0]  x_data,
   output logic [W-1:0]  mul_a,
   output logic [W-1:0]  mul_b,
   input  logic [W-1:0]  mul_p,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [W-1:0]  y_data,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

   state_t         state_q, state_d;
   logic [W-1:0]   d_q    [NTAPS];
   logic [W-1:0]   coef_q [NTAPS];
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   y_q, y_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [W-1:0]   sum;
   logic           accept;

   // A sample is only taken in IDLE; x_ready is purely state-derived.
   assign accept = (state_q == S_IDLE) && x_valid;
   // Running sum including the product of the tap currently on the multiplier.
   assign sum    = acc_q + mul_p;
   assign y_data = y_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: accept -> walk all taps -> hold result until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (x_valid)            state_d = S_MAC;
         S_MAC:   if (idx_q == LAST_IDX)  state_d = S_OUT;
         S_OUT:   if (y_ready)            state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // FSM outputs: handshakes and multiplier operands (zero outside MAC).
   always_comb begin
      x_ready = 1'b0;
      y_valid = 1'b0;
      busy    = 1'b1;
      mul_a   = '0;
      mul_b   = '0;
      unique case (state_q)
         S_IDLE: begin
            x_ready = 1'b1;
            busy    = 1'b0;
         end
         S_MAC: begin
            mul_a = coef_q[idx_q];
            mul_b = d_q[idx_q];
         end
         S_OUT: begin
            y_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Accumulator, tap index and output register next-state.
   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      y_d   = y_q;
      if (accept) begin
         acc_d = '0;
         idx_d = '0;
      end else if (state_q == S_MAC) begin
         acc_d = sum;
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            y_d   = sum;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Accumulator, tap index and output registers; reset discards any result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         idx_q <= '0;
         y_q   <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
         y_q   <= y_d;
      end
   end

   // Delay line: shifts only when a sample is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAPS; k++) d_q[k] <= '0;
      end else if (accept) begin
         d_q[0] <= x_data;
         for (int k = 1; k < NTAPS; k++) d_q[k] <= d_q[k-1];
      end
   end

   // Coefficient bank: writable in any state, out-of-range addresses dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAPS; k++) coef_q[k] <= '0;
      end else if (coef_we && (int'(coef_addr) < NTAPS)) begin
         coef_q[coef_addr] <= coef_wdata;
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed bench for fir_mac_sequencer with a combinational low-W-bit
// multiplier model and hand-computed expected filter outputs.
module tb_fir_mac_sequencer;

   localparam int NTAPS = 3;
   localparam int W     = 32;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          coef_we = 1'b0;
   logic [AW-1:0] coef_addr = '0;
   logic [W-1:0]  coef_wdata = '0;
   logic          x_valid = 1'b0;
   logic          x_ready;
   logic [W-1:0]  x_data = '0;
   logic [W-1:0]  mul_a, mul_b, mul_p;
   logic          y_valid;
   logic          y_ready = 1'b1;
   logic [W-1:0]  y_data;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;

   fir_mac_sequencer #(.NTAPS(NTAPS), .W(W), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .x_valid    (x_valid),
      .x_ready    (x_ready),
      .x_data     (x_data),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .y_data     (y_data),
      .busy       (busy)
   );

   // Shared multiplier model: low W bits of the product.
   assign mul_p = mul_a * mul_b;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int k, input logic [W-1:0] v);
      coef_we    = 1'b1;
      coef_addr  = AW'(k);
      coef_wdata = v;
      tick();
      coef_we    = 1'b0;
   endtask

   // Offer one sample, check MAC status, latency and result.
   // With y_ready low the bench is left sitting in OUT for the caller.
   task automatic send_sample(input logic [W-1:0] x, input logic [W-1:0] exp, input string tag);
      int wt;
      int lat;
      wt = 0;
      while (!x_ready && wt < 20) begin
         tick();
         wt++;
      end
      chk({tag, "_xready"}, W'(x_ready), 1);
      x_valid = 1'b1;
      x_data  = x;
      tick();
      x_valid = 1'b0;
      coef_we = 1'b0;
      chk({tag, "_busy"}, W'(busy), 1);
      lat = 0;
      while (!y_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, W'(lat), W'(NTAPS));
      chk({tag, "_y"}, y_data, exp);
      if (y_ready) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_xready", W'(x_ready), 1);
      chk("rst_yvalid", W'(y_valid), 0);
      chk("rst_busy",   W'(busy), 0);
      chk("rst_mula",   mul_a, 0);
      chk("rst_mulb",   mul_b, 0);
      chk("rst_ydata",  y_data, 0);
      rst_n = 1'b1;
      tick();

      // Impulse
      write_coef(0, 1);
      write_coef(1, 2);
      write_coef(2, 3);
      send_sample(1, 1, "imp0");
      send_sample(0, 2, "imp1");
      send_sample(0, 3, "imp2");
      send_sample(0, 0, "imp3");
      chk("imp_idle_yvalid", W'(y_valid), 0);

      // Steady input
      write_coef(0, 4);
      write_coef(1, 5);
      write_coef(2, 6);
      send_sample(10, 40,  "st0");
      send_sample(20, 130, "st1");
      send_sample(30, 280, "st2");

      // Backpressure: d = {1,30,20} -> 4 + 150 + 120 = 274
      y_ready = 1'b0;
      send_sample(1, 274, "bp");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_y",      y_data, 274);
         chk("bp_hold_yvalid", W'(y_valid), 1);
         chk("bp_hold_xready", W'(x_ready), 0);
      end
      y_ready = 1'b1;
      tick();
      chk("bp_rel_yvalid", W'(y_valid), 0);
      chk("bp_rel_xready", W'(x_ready), 1);
      chk("bp_rel_busy",   W'(busy), 0);

      // Wrap-around
      write_coef(0, 32'hFFFF_FFFF);
      write_coef(1, 0);
      write_coef(2, 0);
      send_sample(2, 32'hFFFF_FFFE, "wrap0");
      write_coef(1, 1);
      send_sample(1, 32'h0000_0001, "wrap1");
      send_sample(1, 32'h0000_0000, "wrap2");

      // Reset in the second MAC cycle (idx 1, coef[1] = 1, d[1] = 1)
      x_valid = 1'b1;
      x_data  = 5;
      tick();
      x_valid = 1'b0;
      tick();
      chk("mac2_mula", mul_a, 1);
      chk("mac2_mulb", mul_b, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_xready", W'(x_ready), 1);
      chk("mrst_yvalid", W'(y_valid), 0);
      chk("mrst_busy",   W'(busy), 0);
      chk("mrst_mula",   mul_a, 0);
      chk("mrst_ydata",  y_data, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("mrst_idle_xready", W'(x_ready), 1);
      chk("mrst_idle_busy",   W'(busy), 0);
      send_sample(1, 0, "mrst_imp");

      // Collision: d = {3,1,0}, coef becomes {7,0,0} on the accept edge
      write_coef(0, 1);
      coef_we    = 1'b1;
      coef_addr  = 0;
      coef_wdata = 7;
      send_sample(3, 21, "coll");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
